// File: rtl/gpio_cond_pkg.sv
// -----------------------------------------------------------------------------
// gpio_cond_pkg
// Shared constants and helpers for the GPIO input conditioner.
//   clog2()     : ceiling log2 for sizing counters at elaboration time
//   width_of()  : clog2() but never less than 1 bit
//   GPIO_TICK_DIV_DEFAULT / GPIO_STABLE_DEFAULT : default debounce timing
// -----------------------------------------------------------------------------
package gpio_cond_pkg;

   // 1 ms sample period at a 50 MHz clock
   localparam int GPIO_TICK_DIV_DEFAULT = 50000;
   localparam int GPIO_STABLE_DEFAULT   = 4;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

   // A counter for 'count' states; a 1-state counter still needs one bit.
   function automatic int width_of(input int count);
      return (clog2(count) < 1) ? 1 : clog2(count);
   endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// -----------------------------------------------------------------------------
// gpio_debounce_bit
// One conditioned input bit: SYNC_STAGES-deep synchroniser, sample-tick driven
// stability counter and registered output. With BYPASS set the synchronised
// level goes straight to the output flop and the counter is not built.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   pin_i        : raw asynchronous pin
//   tick_i       : shared debounce sample strobe
//   data_o       : conditioned level (registered)
//   changed_o    : one-cycle strobe, high in the cycle data_o takes a new value
//   update_o     : combinational "data_o changes on the next edge", used by the
//                  parent to build a registered any-change pulse
// -----------------------------------------------------------------------------
module gpio_debounce_bit
   import gpio_cond_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int STABLE_SAMPLES = GPIO_STABLE_DEFAULT,
   parameter bit BYPASS         = 1'b0,
   parameter bit RESET_BIT      = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin_i,
   input  logic tick_i,
   output logic data_o,
   output logic changed_o,
   output logic update_o
);

   localparam int             CNT_W    = width_of(STABLE_SAMPLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   data_q;
   logic                   data_d;
   logic                   changed_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{RESET_BIT}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   generate
      if (BYPASS) begin : g_bypass
         // The sample tick has no meaning for a bypassed bit.
         logic unused_tick;
         assign unused_tick = tick_i;

         always_comb begin
            data_d = s;
         end
      end else begin : g_debounce
         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;

         // Count consecutive ticks on which the synchronised level disagrees
         // with the output; any agreeing tick restarts the count.
         always_comb begin
            cnt_d  = cnt_q;
            data_d = data_q;
            if (tick_i) begin
               if (s == data_q) begin
                  cnt_d = '0;
               end else if (cnt_q == CNT_LAST) begin
                  data_d = s;
                  cnt_d  = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end
      end
   endgenerate

   assign update_o = data_d ^ data_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q    <= RESET_BIT;
         changed_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         changed_q <= update_o;
      end
   end

   assign data_o    = data_q;
   assign changed_o = changed_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// -----------------------------------------------------------------------------
// gpio_in_conditioner
// Synchronises and debounces WIDTH raw board pins ahead of an input PIO.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   pin_in       : raw asynchronous pins
//   data_out     : conditioned registered word (to the PIO in_port)
//   changed      : per-bit one-cycle strobe when data_out[i] takes a new value
//   any_change   : one-cycle pulse when any bit of data_out updates
//   tick         : debounce sample strobe, one cycle every TICK_DIV clocks
// -----------------------------------------------------------------------------
module gpio_in_conditioner
   import gpio_cond_pkg::*;
#(
   parameter int               WIDTH          = 32,
   parameter int               SYNC_STAGES    = 2,
   parameter int               TICK_DIV       = GPIO_TICK_DIV_DEFAULT,
   parameter int               STABLE_SAMPLES = GPIO_STABLE_DEFAULT,
   parameter logic [WIDTH-1:0] BYPASS_MASK    = '0,
   parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] changed,
   output logic             any_change,
   output logic             tick
);

   localparam int             PRE_W    = width_of(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;
   logic             tick_q;
   logic             tick_d;
   logic [WIDTH-1:0] update;
   logic             any_change_q;

   // The tick is registered off the wrap, so it lands TICK_DIV edges after
   // reset release and then every TICK_DIV edges.
   always_comb begin
      tick_d = (pre_q == PRE_LAST);
      pre_d  = tick_d ? '0 : pre_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q        <= '0;
         tick_q       <= 1'b0;
         any_change_q <= 1'b0;
      end else begin
         pre_q        <= pre_d;
         tick_q       <= tick_d;
         any_change_q <= |update;
      end
   end

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         gpio_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .BYPASS         (BYPASS_MASK[gi]),
            .RESET_BIT      (RESET_VALUE[gi])
         ) u_bit (
            .clk       (clk),
            .reset_n   (reset_n),
            .pin_i     (pin_in[gi]),
            .tick_i    (tick_q),
            .data_o    (data_out[gi]),
            .changed_o (changed[gi]),
            .update_o  (update[gi])
         );
      end
   endgenerate

   assign tick       = tick_q;
   assign any_change = any_change_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// -----------------------------------------------------------------------------
// tb_gpio_in_conditioner
// Directed test of gpio_in_conditioner with TICK_DIV=4, STABLE_SAMPLES=3,
// bit 0 bypassed. Inputs change 1 ns after a rising edge; outputs are read at
// the same point. Timing notes below count edges relative to a reference edge.
// -----------------------------------------------------------------------------
module tb_gpio_in_conditioner;

   logic        clk;
   logic        reset_n;
   logic [31:0] pin_in;
   logic [31:0] data_out;
   logic [31:0] changed;
   logic        any_change;
   logic        tick;

   int n_checks;
   int n_fail;

   gpio_in_conditioner #(
      .WIDTH          (32),
      .SYNC_STAGES    (2),
      .TICK_DIV       (4),
      .STABLE_SAMPLES (3),
      .BYPASS_MASK    (32'h0000_0001),
      .RESET_VALUE    (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .pin_in     (pin_in),
      .data_out   (data_out),
      .changed    (changed),
      .any_change (any_change),
      .tick       (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Step until tick is observed high (bounded); debounce evaluation happens
   // on the edge following this point.
   task automatic wait_tick();
      int n;
      n = 0;
      do begin
         step(1);
         n++;
      end while (tick !== 1'b1 && n < 10);
      check_eq("wait_tick", {31'b0, tick}, 32'h1);
   endtask

   // Check the outputs in one shot.
   task automatic check_out(input string tag, input logic [31:0] exp_data,
                            input logic [31:0] exp_chg, input logic exp_any);
      check_eq({tag, ".data"}, data_out, exp_data);
      check_eq({tag, ".changed"}, changed, exp_chg);
      check_eq({tag, ".any"}, {31'b0, any_change}, {31'b0, exp_any});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      pin_in   = 32'h0;

      // 1. Reset state, then first tick 4 edges after release.
      step(3);
      check_out("reset", 32'h0, 32'h0, 1'b0);
      check_eq("reset.tick", {31'b0, tick}, 32'h0);
      reset_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step(1);
         check_eq($sformatf("tick_e%0d", k), {31'b0, tick}, (k == 4) ? 32'h1 : 32'h0);
      end
      $display("txn reset: first tick checked");

      // 2. Bypass bit 0: output follows 3 edges after the pin changes.
      pin_in[0] = 1'b1;
      step(2);
      check_out("byp_e2", 32'h0, 32'h0, 1'b0);
      step(1);
      check_out("byp_e3", 32'h1, 32'h1, 1'b1);
      step(1);
      check_out("byp_e4", 32'h1, 32'h0, 1'b0);
      $display("txn bypass: bit0 rise");

      // 4. Glitch on bit 5: high across 2 evaluations, low before the 3rd.
      wait_tick();                 // reference T
      pin_in[5] = 1'b1;            // s=1 from T+2; evals at T+5, T+9
      step(9);
      pin_in[5] = 1'b0;            // s=0 from T+11; eval at T+13 clears count
      for (int k = 0; k < 8; k++) begin
         step(1);
         check_out($sformatf("glitch_c%0d", k), 32'h1, 32'h0, 1'b0);
      end
      $display("txn glitch: bit5 pulse rejected");

      // 3. Accept on bit 5: needs 3 full evaluations again (count was cleared).
      wait_tick();                 // reference T
      pin_in[5] = 1'b1;            // evals T+5, T+9, accept at T+13
      step(12);
      check_out("acc_e12", 32'h1, 32'h0, 1'b0);
      step(1);
      check_out("acc_e13", 32'h21, 32'h20, 1'b1);
      step(1);
      check_out("acc_e14", 32'h21, 32'h0, 1'b0);
      $display("txn accept: bit5 rise");

      // 5. Bits 3 and 31 together.
      wait_tick();
      pin_in[3]  = 1'b1;
      pin_in[31] = 1'b1;
      step(12);
      check_out("sim_e12", 32'h21, 32'h0, 1'b0);
      step(1);
      check_out("sim_e13", 32'h8000_0029, 32'h8000_0008, 1'b1);
      step(1);
      check_out("sim_e14", 32'h8000_0029, 32'h0, 1'b0);
      $display("txn simultaneous: bits 3 and 31");

      // 6. Reset in the middle of a count on bit 7.
      wait_tick();                 // reference T
      pin_in[7] = 1'b1;            // evals at T+5, T+9 bring count to 2
      step(9);
      reset_n = 1'b0;
      #1;
      check_out("rst_async", 32'h0, 32'h0, 1'b0);
      check_eq("rst_async.tick", {31'b0, tick}, 32'h0);
      step(2);
      reset_n = 1'b1;              // reference R; evals at R+5, R+9, R+13
      step(2);
      check_out("rel_e2", 32'h0, 32'h0, 1'b0);
      step(1);
      check_out("rel_e3", 32'h1, 32'h1, 1'b1);
      step(9);
      check_out("rel_e12", 32'h1, 32'h0, 1'b0);
      step(1);
      check_out("rel_e13", 32'h8000_00A9, 32'h8000_00A8, 1'b1);
      step(1);
      check_out("rel_e14", 32'h8000_00A9, 32'h0, 1'b0);
      $display("txn reset mid-count: bit7 restarts");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
